// File: rtl/aemb_regf_mt.sv
// aemb_regf_mt: multi-thread AEMB register file with post-reset clear, bypass and load/store sizers
module aemb_regf_mt #(
    parameter int TXE    = 1,
    parameter int BYPASS = 1,
    parameter int SEXT   = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            ena_i,
    output logic                            rdy_o,
    input  logic [((TXE > 0) ? TXE : 1)-1:0] tid_if,
    input  logic [((TXE > 0) ? TXE : 1)-1:0] tid_ma,
    input  logic [4:0]                      ra_if,
    input  logic [4:0]                      rb_if,
    input  logic [4:0]                      rd_if,
    input  logic [4:0]                      rd_ma,
    input  logic [2:0]                      opd_ma,
    input  logic [3:0]                      sel_ma,
    input  logic                            sgn_ma,
    input  logic [31:0]                     res_ma,
    input  logic [31:0]                     mul_ma,
    input  logic [29:0]                     pc_ma,
    input  logic [31:0]                     dwb_dat_i,
    input  logic [31:0]                     cwb_dat_i,
    input  logic                            dwb_ack_i,
    input  logic                            cwb_ack_i,
    input  logic [31:0]                     opm_of,
    input  logic [31:0]                     opa_of,
    input  logic [1:0]                      opc_of,
    output logic [31:0]                     rega_of,
    output logic [31:0]                     regb_of,
    output logic [31:0]                     regd_of,
    output logic [31:0]                     dwb_dat_o,
    output logic [31:0]                     cwb_dat_o
);
    localparam int TW    = (TXE > 0) ? TXE : 1;
    localparam int AW    = 5 + TXE;
    localparam int DEPTH = 32 << TXE;

    typedef enum logic {CLR, RUN} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  clr_cnt;
    logic           clr;
    logic           run;
    logic [31:0]    mem [DEPTH];
    logic [31:0]    dwb_lat, cwb_lat;
    logic [31:0]    ld_dat, wdat;
    logic [7:0]     ld_b;
    logic [15:0]    ld_h;
    logic           sgn;
    logic           we;
    logic [TW+4:0]  wcat;
    logic [AW-1:0]  wa;
    logic [4:0]     rsel [3];
    logic [31:0]    rdat [3];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= CLR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr ? clr_cnt + 1'b1 : clr_cnt;
        end
    end

    always_comb state_nxt = (state == CLR && clr_cnt == AW'(DEPTH - 1)) ? RUN : state;

    always_comb begin
        clr   = state == CLR;
        run   = state == RUN;
        rdy_o = run;
    end

    // Bus read data is captured on ack so writeback sees the value from before this edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dwb_lat <= '0;
            cwb_lat <= '0;
        end else begin
            if (dwb_ack_i) dwb_lat <= dwb_dat_i;
            if (cwb_ack_i) cwb_lat <= cwb_dat_i;
        end
    end

    assign sgn  = (SEXT != 0) && sgn_ma;
    assign ld_b = (sel_ma == 4'h8) ? dwb_lat[31:24] :
                  (sel_ma == 4'h4) ? dwb_lat[23:16] :
                  (sel_ma == 4'h2) ? dwb_lat[15:8]  : dwb_lat[7:0];
    assign ld_h = (sel_ma == 4'hC) ? dwb_lat[31:16] : dwb_lat[15:0];

    always_comb begin
        ld_dat = (sel_ma == 4'h8 || sel_ma == 4'h4 || sel_ma == 4'h2 || sel_ma == 4'h1) ? {{24{sgn & ld_b[7]}}, ld_b} :
                 (sel_ma == 4'hC || sel_ma == 4'h3) ? {{16{sgn & ld_h[15]}}, ld_h} :
                 (sel_ma == 4'hF) ? dwb_lat :
                 (sel_ma == 4'h0) ? cwb_lat : '0;
        wdat   = (opd_ma == 3'd0) ? res_ma :
                 (opd_ma == 3'd1) ? {pc_ma, 2'b00} :
                 (opd_ma == 3'd2) ? ld_dat :
                 (opd_ma == 3'd3) ? mul_ma : '0;
        we     = run && ena_i && (rd_ma != 5'd0) && (opd_ma < 3'd4);
    end

    assign wcat = {tid_ma, rd_ma};
    assign wa   = wcat[AW-1:0];

    // The clear sequencer owns the write port until every entry has been zeroed
    always_ff @(posedge clk_i) begin
        if (clr || we) mem[clr ? clr_cnt : wa] <= clr ? '0 : wdat;
    end

    assign rsel[0] = ra_if;
    assign rsel[1] = rb_if;
    assign rsel[2] = rd_if;

    for (genvar i = 0; i < 3; i++) begin : g_rd
        logic [TW+4:0] rcat;
        logic [AW-1:0] radr;
        assign rcat    = {tid_if, rsel[i]};
        assign radr    = rcat[AW-1:0];
        assign rdat[i] = (clr || rsel[i] == 5'd0) ? '0 :
                         (BYPASS != 0 && we && radr == wa) ? wdat : mem[radr];
    end

    assign rega_of = rdat[0];
    assign regb_of = rdat[1];
    assign regd_of = rdat[2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dwb_dat_o <= '0;
            cwb_dat_o <= '0;
        end else if (ena_i) begin
            if (opc_of == 2'd3) cwb_dat_o <= opa_of;
            else dwb_dat_o <= (opc_of == 2'd0) ? {4{opm_of[7:0]}} :
                              (opc_of == 2'd1) ? {2{opm_of[15:0]}} : opm_of;
        end
    end
endmodule

// File: tb/tb_aemb_regf_mt.sv
// tb_aemb_regf_mt: directed tables plus randomized traffic checked against a behavioural register-file model
module tb_aemb_regf_mt;
    localparam int DEPTH = 64;

    logic        clk_i = 0, rst_i = 0, ena_i = 0;
    logic        tid_if = 0, tid_ma = 0;
    logic [4:0]  ra_if = 0, rb_if = 0, rd_if = 0, rd_ma = 0;
    logic [2:0]  opd_ma = 7;
    logic [3:0]  sel_ma = 0;
    logic        sgn_ma = 0;
    logic [31:0] res_ma = 0, mul_ma = 0;
    logic [29:0] pc_ma = 0;
    logic [31:0] dwb_dat_i = 0, cwb_dat_i = 0;
    logic        dwb_ack_i = 0, cwb_ack_i = 0;
    logic [31:0] opm_of = 0, opa_of = 0;
    logic [1:0]  opc_of = 0;
    logic        rdy_o;
    logic [31:0] rega_of, regb_of, regd_of, dwb_dat_o, cwb_dat_o;

    aemb_regf_mt #(.TXE(1), .BYPASS(1), .SEXT(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .rdy_o(rdy_o),
        .tid_if(tid_if), .tid_ma(tid_ma), .ra_if(ra_if), .rb_if(rb_if), .rd_if(rd_if),
        .rd_ma(rd_ma), .opd_ma(opd_ma), .sel_ma(sel_ma), .sgn_ma(sgn_ma),
        .res_ma(res_ma), .mul_ma(mul_ma), .pc_ma(pc_ma),
        .dwb_dat_i(dwb_dat_i), .cwb_dat_i(cwb_dat_i), .dwb_ack_i(dwb_ack_i), .cwb_ack_i(cwb_ack_i),
        .opm_of(opm_of), .opa_of(opa_of), .opc_of(opc_of),
        .rega_of(rega_of), .regb_of(regb_of), .regd_of(regd_of),
        .dwb_dat_o(dwb_dat_o), .cwb_dat_o(cwb_dat_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] regs [2][32];
    bit          m_rdy;
    int          m_clr;
    logic [31:0] m_dl, m_cl, m_dwo, m_cwo;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [3:0]  sel;
        logic        sgn;
        logic [31:0] exp;
    } ld_vec_t;
    ld_vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 32; r++) regs[t][r] = '0;
        m_rdy = 0;
        m_clr = DEPTH;
        m_dl = '0; m_cl = '0; m_dwo = '0; m_cwo = '0;
    endtask

    function automatic logic [31:0] m_load();
        int lane, bits;
        logic [31:0] v, mask;
        case (sel_ma)
            4'h8: begin lane = 3; bits = 8; end
            4'h4: begin lane = 2; bits = 8; end
            4'h2: begin lane = 1; bits = 8; end
            4'h1: begin lane = 0; bits = 8; end
            4'hC: begin lane = 2; bits = 16; end
            4'h3: begin lane = 0; bits = 16; end
            4'hF: return m_dl;
            4'h0: return m_cl;
            default: return '0;
        endcase
        mask = (32'h1 << bits) - 32'h1;
        v = (m_dl >> (8 * lane)) & mask;
        if (sgn_ma && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] m_wdat();
        case (opd_ma)
            3'd0: return res_ma;
            3'd1: return {pc_ma, 2'b00};
            3'd2: return m_load();
            3'd3: return mul_ma;
            default: return '0;
        endcase
    endfunction

    function automatic bit m_we();
        return m_rdy && ena_i && rd_ma != 0 && opd_ma < 4;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (!m_rdy || r == 0) return '0;
        if (m_we() && tid_ma == tid_if && rd_ma == r) return m_wdat();
        return regs[tid_if][r];
    endfunction

    task automatic step();
        logic [31:0] wd;
        bit we;
        wd = m_wdat();
        we = m_we();
        @(posedge clk_i);
        if (rst_i) begin
            if (!m_rdy) begin
                m_clr--;
                if (m_clr == 0) m_rdy = 1;
            end else if (we) regs[tid_ma][rd_ma] = wd;
            if (dwb_ack_i) m_dl = dwb_dat_i;
            if (cwb_ack_i) m_cl = cwb_dat_i;
            if (ena_i) begin
                if (opc_of == 3) m_cwo = opa_of;
                else m_dwo = (opc_of == 0) ? (opm_of & 32'hFF) * 32'h01010101 :
                             (opc_of == 1) ? (opm_of & 32'hFFFF) * 32'h00010001 : opm_of;
            end
        end
        #1;
    endtask

    task automatic check_all(input string name);
        chk({name, "_rdy"}, 32'(rdy_o), 32'(m_rdy));
        chk({name, "_ra"}, rega_of, m_read(ra_if));
        chk({name, "_rb"}, regb_of, m_read(rb_if));
        chk({name, "_rd"}, regd_of, m_read(rd_if));
        chk({name, "_dwbo"}, dwb_dat_o, m_dwo);
        chk({name, "_cwbo"}, cwb_dat_o, m_cwo);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        ena_i = 1; opd_ma = 0; tid_ma = 0; rd_ma = 3; res_ma = 32'h55;
        tid_if = 0; ra_if = 3;
        while (!rdy_o && n < 200) begin
            if (n == 10) chk({name, "_clr_read"}, rega_of, 32'h0);
            step();
            n++;
        end
        ena_i = 0; opd_ma = 7;
        chk({name, "_len"}, 32'(n), 32'(DEPTH));
        for (int t = 0; t < 2; t++)
            for (int r = 0; r < 32; r++) begin
                tid_if = 1'(t); ra_if = 5'(r);
                #1 chk({name, "_zero"}, rega_of, 32'h0);
            end
    endtask

    initial begin
        tbl[0]  = '{4'h8, 1'b1, 32'hFFFFFF80};
        tbl[1]  = '{4'h8, 1'b0, 32'h00000080};
        tbl[2]  = '{4'h4, 1'b1, 32'hFFFFFFFF};
        tbl[3]  = '{4'h4, 1'b0, 32'h000000FF};
        tbl[4]  = '{4'h2, 1'b1, 32'h0000007F};
        tbl[5]  = '{4'h1, 1'b0, 32'h00000001};
        tbl[6]  = '{4'hC, 1'b1, 32'hFFFF80FF};
        tbl[7]  = '{4'hC, 1'b0, 32'h000080FF};
        tbl[8]  = '{4'h3, 1'b1, 32'h00007F01};
        tbl[9]  = '{4'hF, 1'b1, 32'h80FF7F01};
        tbl[10] = '{4'h0, 1'b0, 32'hCAFEF00D};
        tbl[11] = '{4'h5, 1'b1, 32'h00000000};

        m_reset();
        rst_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_rdy", 32'(rdy_o), 32'h0);
        chk("rst_dwbo", dwb_dat_o, 32'h0);
        chk("rst_cwbo", cwb_dat_o, 32'h0);
        rst_i = 1;
        wait_ready("init");

        tid_ma = 1; rd_ma = 5; opd_ma = 0; res_ma = 32'hDEADBEEF; ena_i = 1;
        step();
        ena_i = 0; opd_ma = 7; ra_if = 5;
        tid_if = 0; #1 chk("thr0_r5", rega_of, 32'h0);
        tid_if = 1; #1 chk("thr1_r5", rega_of, 32'hDEADBEEF);

        tid_ma = 0; tid_if = 0; rd_ma = 7; rb_if = 7; opd_ma = 0; res_ma = 32'h12345678; ena_i = 1;
        #1 chk("bypass_r7", regb_of, 32'h12345678);
        step();
        ena_i = 0;
        #1 chk("stored_r7", regb_of, 32'h12345678);
        rd_ma = 0; rd_if = 0; res_ma = 32'hFFFFFFFF; ena_i = 1;
        #1 chk("r0_bypass", regd_of, 32'h0);
        step();
        ena_i = 0;
        #1 chk("r0_stored", regd_of, 32'h0);

        dwb_dat_i = 32'h80FF7F01; cwb_dat_i = 32'hCAFEF00D; dwb_ack_i = 1; cwb_ack_i = 1;
        step();
        dwb_ack_i = 0; cwb_ack_i = 0;
        for (int k = 0; k < 12; k++) begin
            sel_ma = tbl[k].sel; sgn_ma = tbl[k].sgn;
            opd_ma = 2; rd_ma = 9; tid_ma = 0; tid_if = 0; ra_if = 9; ena_i = 1;
            #1 chk($sformatf("load_byp_%0d", k), rega_of, tbl[k].exp);
            step();
            ena_i = 0;
            #1 chk($sformatf("load_st_%0d", k), rega_of, tbl[k].exp);
        end

        sel_ma = 4'hF; opd_ma = 2; rd_ma = 10; ena_i = 1; dwb_dat_i = 32'h11223344; dwb_ack_i = 1;
        step();
        dwb_ack_i = 0; rd_ma = 11;
        step();
        ena_i = 0; opd_ma = 7;
        ra_if = 10; rb_if = 11;
        #1 chk("ack_pre", rega_of, 32'h80FF7F01);
        chk("ack_post", regb_of, 32'h11223344);

        ena_i = 1; opc_of = 0; opm_of = 32'hAB;
        step();
        chk("st_byte", dwb_dat_o, 32'hABABABAB);
        opc_of = 3; opa_of = 32'h5;
        step();
        chk("st_fsl_cwb", cwb_dat_o, 32'h5);
        chk("st_fsl_dwb", dwb_dat_o, 32'hABABABAB);
        ena_i = 0; opc_of = 1; opm_of = 32'h1234;
        step();
        chk("st_hold_dwb", dwb_dat_o, 32'hABABABAB);
        chk("st_hold_cwb", cwb_dat_o, 32'h5);

        for (int k = 0; k < 400; k++) begin
            ena_i = 1'($urandom_range(0, 3) != 0);
            tid_if = 1'($urandom); tid_ma = 1'($urandom);
            ra_if = 5'($urandom); rb_if = 5'($urandom); rd_if = 5'($urandom);
            rd_ma = ($urandom_range(0, 3) == 0) ? ra_if : 5'($urandom);
            opd_ma = 3'($urandom); sel_ma = 4'($urandom); sgn_ma = 1'($urandom);
            res_ma = $urandom; mul_ma = $urandom; pc_ma = 30'($urandom);
            dwb_dat_i = $urandom; cwb_dat_i = $urandom;
            dwb_ack_i = 1'($urandom); cwb_ack_i = 1'($urandom);
            opm_of = $urandom; opa_of = $urandom; opc_of = 2'($urandom);
            #1 check_all("rnd");
            step();
        end
        dwb_ack_i = 0; cwb_ack_i = 0;

        tid_ma = 1; rd_ma = 12; opd_ma = 0; res_ma = 32'hA5A5A5A5; ena_i = 1; opc_of = 2; opm_of = 32'h77;
        step();
        ena_i = 0; opd_ma = 7; tid_if = 1; ra_if = 12;
        #1 chk("pre_rst_r12", rega_of, 32'hA5A5A5A5);
        #2 rst_i = 0;
        #1;
        chk("mid_rst_rdy", 32'(rdy_o), 32'h0);
        chk("mid_rst_dwbo", dwb_dat_o, 32'h0);
        chk("mid_rst_cwbo", cwb_dat_o, 32'h0);
        chk("mid_rst_read", rega_of, 32'h0);
        m_reset();
        step();
        rst_i = 1;
        wait_ready("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
